// File: rtl/bch_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bch_enc_ctrl
// Purpose  : Sequencing controller for a BCH(63,51) serial encoder datapath.
//            It accepts one message per valid/ready handshake and pulses the
//            PISO load and LFSR clear. It then frames 51 message bits followed
//            by 12 parity bits, and gates the LFSR shift and feedback while
//            steering the output mux.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            msg_valid/ready- message handshake (ready never depends on valid)
//            load, lfsr_clr - strobes issued only on an accepted handshake
//            shift_en,fb_en - LFSR advance / feedback (feedback in data phase)
//            par_sel        - output mux: 0 = PISO bit, 1 = parity bit
//            out_valid/sop/eop - codeword framing
//            busy           - codeword in progress
//            cw_cnt         - completed codewords, wraps modulo 2^CNT_W
// Revision : 1.0 - initial release
// ============================================================================
module bch_enc_ctrl #(
  parameter int K     = 51,
  parameter int N     = 63,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic             load,
  output logic             lfsr_clr,
  output logic             shift_en,
  output logic             fb_en,
  output logic             par_sel,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             busy,
  output logic [CNT_W-1:0] cw_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  localparam logic [5:0] C_DATA_LAST = 6'(K - 1);
  localparam logic [5:0] C_PAR_LAST  = 6'(N - K - 1);
  localparam logic [CNT_W-1:0] C_CW_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] cw_cnt_q, cw_cnt_d;

  // Strobes are decoded from state/cnt so that load and lfsr_clr coincide
  // with the handshake cycle. msg_ready is derived from state/cnt only,
  // which keeps msg_valid -> msg_ready free of any combinational path.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cw_cnt_d  = cw_cnt_q;
    msg_ready = 1'b0;
    load      = 1'b0;
    lfsr_clr  = 1'b0;
    shift_en  = 1'b0;
    fb_en     = 1'b0;
    par_sel   = 1'b0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          load     = 1'b1;
          lfsr_clr = 1'b1;
          state_d  = S_DATA;
          cnt_d    = 6'd0;
        end
      end

      S_DATA: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        shift_en  = 1'b1;
        fb_en     = 1'b1;
        out_sop   = (cnt_q == 6'd0);
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == C_DATA_LAST) begin
          state_d = S_PARITY;
          cnt_d   = 6'd0;
        end
      end

      S_PARITY: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        shift_en  = 1'b1;
        par_sel   = 1'b1;
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == C_PAR_LAST) begin
          out_eop   = 1'b1;
          msg_ready = 1'b1;
          cw_cnt_d  = cw_cnt_q + C_CW_ONE;
          cnt_d     = 6'd0;
          // Accepting here chains codewords with no idle bit in between.
          if (msg_valid) begin
            load     = 1'b1;
            lfsr_clr = 1'b1;
            state_d  = S_DATA;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase

    // Reset forces every output low in the same cycle, which also blocks a
    // handshake that coincides with reset.
    if (reset) begin
      msg_ready = 1'b0;
      load      = 1'b0;
      lfsr_clr  = 1'b0;
      shift_en  = 1'b0;
      fb_en     = 1'b0;
      par_sel   = 1'b0;
      out_valid = 1'b0;
      out_sop   = 1'b0;
      out_eop   = 1'b0;
      busy      = 1'b0;
    end
  end

  assign cw_cnt = reset ? '0 : cw_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      cw_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cw_cnt_q <= cw_cnt_d;
    end
  end

endmodule
`default_nettype wire
